// File: rtl/pll_dyn_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_dyn_cfg                                                              |
// | Handshake-loaded divider reconfiguration and lock qualification for a    |
// | dynamic-ratio PLL: reset sequencing, debounce, retry and relock.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pll_dyn_cfg #(
  parameter int                    NUM_OUT      = 3,
  parameter logic [9:0]            DEF_IDIV     = 10'd3,
  parameter logic [9:0]            DEF_FDIV     = 10'd49,
  parameter logic [NUM_OUT*10-1:0] DEF_ODIV     = {10'd33, 10'd82, 10'd11},
  parameter int                    RST_CYCLES   = 16,
  parameter int                    LOCK_STABLE  = 256,
  parameter int                    LOCK_TIMEOUT = 4096,
  parameter int                    MAX_RETRY    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [9:0]              cfg_idiv,
  input  logic [9:0]              cfg_fdiv,
  input  logic [NUM_OUT*10-1:0]   cfg_odiv,
  output logic                    cfg_err,
  output logic                    cfg_done,
  input  logic                    pll_lock,
  output logic                    pll_rst,
  output logic                    rstodiv,
  output logic [9:0]              dyn_idiv,
  output logic [9:0]              dyn_fdiv,
  output logic [NUM_OUT*10-1:0]   dyn_odiv,
  output logic [NUM_OUT*10-1:0]   dyn_duty,
  output logic                    locked,
  output logic                    lock_fail
);

  localparam int c_CNT_MAX = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int c_RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(LOCK_STABLE - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_RTY_W-1:0] c_RTY_LAST = c_RTY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    HOLD_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    ERROR     = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [c_RTY_W-1:0]   r_retry, w_retry_nxt;
  logic                 w_done;

  logic                 r_lock_meta, r_lock_s;
  logic                 r_pll_rst, r_rstodiv, r_locked, r_cfg_ready;
  logic                 r_lock_fail, r_cfg_done, r_cfg_err;
  logic [9:0]           r_idiv, r_fdiv;
  logic [NUM_OUT*10-1:0] r_odiv;

  logic [NUM_OUT-1:0]   w_odiv_zero;
  logic                 w_cfg_bad, w_accept, w_load;

  // pll_lock comes from the PLL's own clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
    assign w_odiv_zero[gi] = (cfg_odiv[gi*10 +: 10] == 10'd0);
  end

  assign w_cfg_bad = (cfg_idiv == 10'd0) || (cfg_fdiv == 10'd0) || (|w_odiv_zero);
  assign w_accept  = cfg_valid && r_cfg_ready;
  assign w_load    = w_accept && !w_cfg_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD_RST;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_retry_nxt = r_retry;
    w_done      = 1'b0;
    case (r_state)
      HOLD_RST: begin
        if (r_cnt == c_RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      WAIT_LOCK, STABLE: begin
        w_tmo_nxt = r_tmo + c_TMO_W'(1);
        if (r_state == WAIT_LOCK) begin
          if (r_lock_s) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end
        end else if (!r_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == c_STB_LAST) begin
          w_state_nxt = RUN;
          w_retry_nxt = '0;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
        // A lock qualified on the very last timeout cycle still counts
        if (r_tmo == c_TMO_LAST && w_state_nxt != RUN) begin
          w_cnt_nxt   = '0;
          w_retry_nxt = r_retry + c_RTY_W'(1);
          w_state_nxt = (r_retry < c_RTY_LAST) ? HOLD_RST : ERROR;
        end
      end
      RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = HOLD_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = HOLD_RST;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_load) begin
      w_state_nxt = HOLD_RST;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end
  end

  // Outputs are registered decodes of the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_rstodiv   <= 1'b1;
      r_locked    <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_lock_fail <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_nxt == HOLD_RST) || (w_state_nxt == ERROR);
      r_rstodiv   <= (w_state_nxt != RUN);
      r_locked    <= (w_state_nxt == RUN);
      r_cfg_ready <= (w_state_nxt == RUN) || (w_state_nxt == ERROR);
      r_lock_fail <= (w_state_nxt == ERROR);
      r_cfg_done  <= w_done;
      r_cfg_err   <= w_accept && w_cfg_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idiv <= DEF_IDIV;
      r_fdiv <= DEF_FDIV;
      r_odiv <= DEF_ODIV;
    end else if (w_load) begin
      r_idiv <= cfg_idiv;
      r_fdiv <= cfg_fdiv;
      r_odiv <= cfg_odiv;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign rstodiv   = r_rstodiv;
  assign locked    = r_locked;
  assign cfg_ready = r_cfg_ready;
  assign lock_fail = r_lock_fail;
  assign cfg_done  = r_cfg_done;
  assign cfg_err   = r_cfg_err;
  assign dyn_idiv  = r_idiv;
  assign dyn_fdiv  = r_fdiv;
  assign dyn_odiv  = r_odiv;
  assign dyn_duty  = r_odiv;

endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pll_dyn_cfg                                                           |
// | Directed bench with a PLL lock model and a completion scoreboard.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pll_dyn_cfg;

  localparam logic [29:0] c_DEF_ODIV = {10'd33, 10'd82, 10'd11};
  localparam logic [29:0] c_ODIV_B   = {10'd33, 10'd82, 10'd10};
  localparam logic [29:0] c_ODIV_C   = {10'd20, 10'd21, 10'd22};
  localparam logic [29:0] c_ODIV_D   = {10'd5,  10'd6,  10'd7};
  localparam logic [29:0] c_ODIV_E   = {10'd12, 10'd13, 10'd14};
  localparam logic [29:0] c_ODIV_BAD = {10'd7,  10'd0,  10'd9};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [9:0]  cfg_idiv = '0;
  logic [9:0]  cfg_fdiv = '0;
  logic [29:0] cfg_odiv = '0;
  logic        cfg_ready, cfg_err, cfg_done;
  logic        pll_lock, pll_rst, rstodiv, locked, lock_fail;
  logic [9:0]  dyn_idiv, dyn_fdiv;
  logic [29:0] dyn_odiv, dyn_duty;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    bit          err;
    logic [9:0]  idiv;
    logic [9:0]  fdiv;
    logic [29:0] odiv;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  bit pll_en = 1'b1;
  bit drop   = 1'b0;
  int since_rel = 0;

  pll_dyn_cfg #(.NUM_OUT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv), .cfg_odiv(cfg_odiv),
    .cfg_err(cfg_err), .cfg_done(cfg_done),
    .pll_lock(pll_lock), .pll_rst(pll_rst), .rstodiv(rstodiv),
    .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty),
    .locked(locked), .lock_fail(lock_fail)
  );

  always #5 clk = ~clk;

  // PLL model: lock rises 100 cycles after its reset is released
  always @(posedge clk) begin
    if (pll_rst) since_rel <= 0;
    else         since_rel <= since_rel + 1;
  end
  assign pll_lock = pll_en && !drop && !pll_rst && (since_rel >= 100);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit err, input logic [9:0] i, input logic [9:0] f,
                               input logic [29:0] o);
    exp_t e;
    e.err = err; e.idiv = i; e.fdiv = f; e.odiv = o;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (cfg_done || cfg_err)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {30'd0, cfg_done, cfg_err}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_err_kind",  cfg_err,  sb_e.err);
        chk("sb_done_kind", cfg_done, !sb_e.err);
        chk("sb_idiv", dyn_idiv, sb_e.idiv);
        chk("sb_fdiv", dyn_fdiv, sb_e.fdiv);
        chk("sb_odiv", dyn_odiv, sb_e.odiv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [9:0] i, input logic [9:0] f, input logic [29:0] o);
    cfg_idiv = i; cfg_fdiv = f; cfg_odiv = o; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic measure_rst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_locked(input int budget, output int n);
    n = 0;
    while (locked !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int falls;
    bit prev;

    #1 rst_n = 1'b0;
    #3;
    chk("rst_pll_rst",   pll_rst,   1);
    chk("rst_rstodiv",   rstodiv,   1);
    chk("rst_locked",    locked,    0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_err",   cfg_err,   0);
    chk("rst_cfg_done",  cfg_done,  0);
    chk("rst_lock_fail", lock_fail, 0);
    chk("rst_idiv",      dyn_idiv,  3);
    chk("rst_fdiv",      dyn_fdiv,  49);
    chk("rst_odiv",      dyn_odiv,  c_DEF_ODIV);

    // power-up with defaults
    push(1'b0, 10'd3, 10'd49, c_DEF_ODIV);
    @(negedge clk);
    rst_n = 1'b1;
    measure_rst(n);
    chk("pwr_rst_len", n, 16);
    wait_locked(1000, n);
    chk("pwr_lock_lat", (n >= 358 && n <= 359), 1);
    chk("pwr_done",     cfg_done, 1);
    chk("pwr_rstodiv",  rstodiv,  0);
    chk("pwr_ready",    cfg_ready, 1);
    chk("pwr_odiv0",    dyn_odiv[9:0], 11);
    tick();
    chk("pwr_done_pulse", cfg_done, 0);

    // reconfigure in RUN
    push(1'b0, 10'd2, 10'd40, c_ODIV_B);
    offer(10'd2, 10'd40, c_ODIV_B);
    chk("rcfg_idiv",    dyn_idiv, 2);
    chk("rcfg_fdiv",    dyn_fdiv, 40);
    chk("rcfg_odiv",    dyn_odiv, c_ODIV_B);
    chk("rcfg_duty",    dyn_duty, c_ODIV_B);
    chk("rcfg_pll_rst", pll_rst, 1);
    chk("rcfg_rstodiv", rstodiv, 1);
    chk("rcfg_locked",  locked, 0);
    chk("rcfg_ready",   cfg_ready, 0);
    measure_rst(n);
    chk("rcfg_rst_len", n, 16);
    wait_locked(1000, n);
    chk("rcfg_lock_lat", (n >= 358 && n <= 359), 1);
    chk("rcfg_done",     cfg_done, 1);

    // invalid configuration: output channel 1 is zero
    tick();
    push(1'b1, 10'd2, 10'd40, c_ODIV_B);
    offer(10'd5, 10'd6, c_ODIV_BAD);
    chk("bad_err",    cfg_err, 1);
    chk("bad_ready",  cfg_ready, 1);
    chk("bad_locked", locked, 1);
    chk("bad_odiv",   dyn_odiv, c_ODIV_B);
    tick();
    chk("bad_err_pulse", cfg_err, 0);
    chk("bad_locked2",   locked, 1);

    // lock drops for 5 cycles in RUN: relock with the same dividers
    push(1'b0, 10'd2, 10'd40, c_ODIV_B);
    drop = 1'b1;
    repeat (5) tick();
    drop = 1'b0;
    chk("drop_locked",  locked, 0);
    chk("drop_pll_rst", pll_rst, 1);
    chk("drop_idiv",    dyn_idiv, 2);
    chk("drop_odiv",    dyn_odiv, c_ODIV_B);
    wait_locked(1000, n);
    chk("drop_relock",  locked, 1);

    // lock glitch at stable count 200 restarts the debounce
    tick();
    push(1'b0, 10'd4, 10'd30, c_ODIV_C);
    offer(10'd4, 10'd30, c_ODIV_C);
    measure_rst(n);
    n = 0;
    while (pll_lock !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("stb_raw_lock", n, 100);
    repeat (203) tick();
    drop = 1'b1;
    repeat (3) tick();
    drop = 1'b0;
    chk("stb_not_locked", locked, 0);
    wait_locked(1000, n);
    chk("stb_restart_lat", (n >= 258 && n <= 260), 1);

    // lock never arrives: three attempts then ERROR
    tick();
    pll_en = 1'b0;
    offer(10'd8, 10'd50, c_ODIV_D);
    falls = 0;
    prev  = pll_rst;
    n     = 0;
    while (lock_fail !== 1'b1 && n < 13000) begin
      tick();
      n++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
    end
    chk("tmo_falls",     falls, 3);
    chk("tmo_cycles",    (n >= 12333 && n <= 12339), 1);
    chk("tmo_lock_fail", lock_fail, 1);
    chk("tmo_pll_rst",   pll_rst, 1);
    chk("tmo_rstodiv",   rstodiv, 1);
    chk("tmo_ready",     cfg_ready, 1);
    chk("tmo_locked",    locked, 0);
    chk("tmo_idiv",      dyn_idiv, 8);

    // recovery from ERROR; cfg_valid held through HOLD_RST is ignored
    pll_en = 1'b1;
    push(1'b0, 10'd9, 10'd60, c_ODIV_E);
    offer(10'd9, 10'd60, c_ODIV_E);
    chk("rec_lock_fail", lock_fail, 0);
    chk("rec_pll_rst",   pll_rst, 1);
    chk("rec_idiv",      dyn_idiv, 9);
    cfg_idiv = 10'd7; cfg_fdiv = 10'd7; cfg_odiv = c_ODIV_D; cfg_valid = 1'b1;
    repeat (10) tick();
    cfg_valid = 1'b0;
    chk("hold_ign_idiv",  dyn_idiv, 9);
    chk("hold_ign_odiv",  dyn_odiv, c_ODIV_E);
    chk("hold_ign_ready", cfg_ready, 0);
    wait_locked(1000, n);
    chk("rec_locked", locked, 1);

    // asynchronous reset during WAIT_LOCK discards the in-flight configuration
    tick();
    offer(10'd11, 10'd22, c_ODIV_B);
    measure_rst(n);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_rstodiv", rstodiv, 1);
    chk("arst_idiv",    dyn_idiv, 3);
    chk("arst_fdiv",    dyn_fdiv, 49);
    chk("arst_odiv",    dyn_odiv, c_DEF_ODIV);
    chk("arst_duty",    dyn_duty, c_DEF_ODIV);
    chk("arst_locked",  locked, 0);
    chk("arst_ready",   cfg_ready, 0);
    push(1'b0, 10'd3, 10'd49, c_DEF_ODIV);
    @(negedge clk);
    rst_n = 1'b1;
    measure_rst(n);
    chk("arst_rst_len", n, 16);
    wait_locked(1000, n);
    chk("arst_relock", locked, 1);

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_dyn_cfg.md
# pll_dyn_cfg

Runtime reconfiguration controller for the GTP_PLL_E3 primitive with dynamic ratios enabled. It replaces fixed divider settings with a handshake-loaded configuration. On each new configuration it sequences the PLL through reset, then qualifies lock with a debounce window. It retries on lock timeout, recovers from lock loss, and presents a clean `locked` status to downstream clock-domain reset logic.

## Interface

Parameters:
- `NUM_OUT`, default 3: number of output dividers driven, 1..5.
- `DEF_IDIV`, default 3: input divider loaded at reset.
- `DEF_FDIV`, default 49: feedback divider loaded at reset.
- `DEF_ODIV`, default {10'd33,10'd82,10'd11}: `NUM_OUT`×10-bit output dividers loaded at reset; channel 0 in bits [9:0].
- `RST_CYCLES`, default 16: PLL reset hold length, ≥2.
- `LOCK_STABLE`, default 256: consecutive synced-lock cycles required.
- `LOCK_TIMEOUT`, default 4096: cycles allowed from reset release to qualified lock.
- `MAX_RETRY`, default 3: lock attempts per configuration before error, ≥1.

Ports:
- `clk` in 1: control clock, free-running, independent of PLL outputs.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: new configuration offered.
- `cfg_ready` out 1: controller can accept a configuration.
- `cfg_idiv` in 10: requested input divider.
- `cfg_fdiv` in 10: requested feedback divider.
- `cfg_odiv` in `NUM_OUT`×10: requested output dividers.
- `cfg_err` out 1: one-cycle pulse when an accepted configuration is rejected.
- `cfg_done` out 1: one-cycle pulse when a configuration reaches qualified lock.
- `pll_lock` in 1: raw PLL LOCK; asynchronous to `clk`.
- `pll_rst` out 1: to PLL RST.
- `rstodiv` out 1: to PLL RSTODIV.
- `dyn_idiv` out 10: to RATIOI.
- `dyn_fdiv` out 10: to RATIOF.
- `dyn_odiv` out `NUM_OUT`×10: to RATIO0..RATIO(`NUM_OUT`-1).
- `dyn_duty` out `NUM_OUT`×10: to DUTY0..; equals `dyn_odiv`, giving 50% duty.
- `locked` out 1: qualified lock.
- `lock_fail` out 1: sticky flag; retries are exhausted.

## Operation

- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- States: HOLD_RST, WAIT_LOCK, STABLE, RUN, ERROR.
- Reset values:
  - State is HOLD_RST, with its counter at 0 and `retry`=0.
  - `dyn_*` hold the DEF_* values.
  - `pll_rst`=1 and `rstodiv`=1.
  - `locked`, `cfg_ready`, `cfg_err`, `cfg_done` and `lock_fail` are all 0.
- HOLD_RST: `pll_rst`=1 and `rstodiv`=1 for exactly `RST_CYCLES` cycles, then go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK: `pll_rst`=0. When `lock_s`=1, go to STABLE and clear the stable counter.
- STABLE: the stable counter increments while `lock_s`=1.
  - If `lock_s`=0, return to WAIT_LOCK. The timeout counter is NOT cleared.
  - When the count reaches `LOCK_STABLE`, go to RUN and make these changes: `rstodiv`=0, `locked`=1, pulse `cfg_done`, clear `retry`.
- Timeout counter: runs in both WAIT_LOCK and STABLE. When it reaches `LOCK_TIMEOUT`, `retry` increments.
  - If the new `retry` < `MAX_RETRY`, go to HOLD_RST.
  - Otherwise go to ERROR.
- RUN: `cfg_ready`=1.
  - If `lock_s`=0, then on the next cycle: `locked`=0, `rstodiv`=1, `cfg_ready`=0, state HOLD_RST, `retry`=0.
  - This relock keeps the current dividers.
- ERROR: `pll_rst`=1, `rstodiv`=1, `lock_fail`=1, `cfg_ready`=1.
- Acceptance: a configuration is accepted only when `cfg_valid` && `cfg_ready`. It is ignored in any other state.
- Validation:
  - A configuration is invalid if any of `cfg_idiv`, `cfg_fdiv` or any `cfg_odiv` channel equals 0.
  - Invalid: pulse `cfg_err`; the dividers and the state are unchanged.
  - Valid: latch the dividers into `dyn_*`, clear `lock_fail` and `retry`, set `locked`=0, go to HOLD_RST.
- If `lock_s` falls on the same cycle a valid configuration is accepted in RUN, the configuration wins: its dividers are latched.

## Timing

- Valid configuration accepted at edge T. At T+1:
  - `dyn_*` are updated.
  - `pll_rst`=1, `rstodiv`=1, `locked`=0, `cfg_ready`=0.
- `pll_rst` is high for cycles T+1 through T+`RST_CYCLES`, and low from T+`RST_CYCLES`+1.
- Raw-lock latency to STABLE entry: 2 sync cycles plus 1.
- `locked` and `cfg_done` assert the cycle after the `LOCK_STABLE`-th consecutive `lock_s` high.
- An invalid configuration accepted at T gives `cfg_err`=1 during T+1 only; `cfg_ready` stays 1.
- `rst_n` low at any time: all outputs take their reset values immediately (asynchronous). An in-flight configuration is discarded.

## Test plan

- Power-up with defaults (`RST_CYCLES`=16, `LOCK_STABLE`=256), PLL model locking 100 cycles after `pll_rst` falls:
  - `pll_rst` is high for 16 cycles.
  - `locked` and `cfg_done` assert 100+2+256(±1) cycles after `pll_rst` falls.
  - `dyn_odiv0`=11.
- Reconfigure in RUN with idiv=2, fdiv=40, odiv0=10:
  - Outputs update at T+1.
  - `pll_rst` is high 16 cycles.
  - `locked` re-asserts with `cfg_done`.
- Offer `cfg_odiv` channel 1 = 0 in RUN:
  - `cfg_err` pulses 1 cycle.
  - `dyn_*` are unchanged and `locked` stays 1.
- Lock never arrives (`LOCK_TIMEOUT`=4096, `MAX_RETRY`=3):
  - Exactly 3 HOLD_RST/WAIT_LOCK passes, then ERROR with `lock_fail`=1 and `pll_rst`=1.
  - A subsequent valid configuration clears `lock_fail`.
- Lock glitches:
  - `pll_lock` drops for 5 cycles in RUN: `locked`=0 and a relock runs with the same dividers.
  - `pll_lock` drops for 3 cycles at count 200 of STABLE: the stable count restarts.
- `cfg_valid` held during HOLD_RST: ignored.
- `rst_n` pulsed during WAIT_LOCK: `dyn_*` return to the DEF_* values and `pll_rst`=1 asynchronously.
